// File: rtl/aes_mode_stream_ctrl.sv
// aes_mode_stream_ctrl
// Splits a DATA_W-bit message into 128-bit blocks, drives an external AES core
// over a start/done handshake and applies CFB (enc/dec), OFB or CTR chaining.
// The key goes straight to the core and never passes through this block.
//
// Ports:
//   clk, reset         clock, asynchronous active-low reset
//   in_valid/in_ready  message handshake (in_ready high only while idle)
//   data_in            message, MSB-first; last block MSB-aligned if partial
//   mode               0=CFB, 1=OFB, 2=CTR, 3=reserved (reports err)
//   decrypt            CFB only: use input ciphertext as feedback
//   iv, nonce          initial feedback for CFB/OFB and CTR respectively
//   out_valid/out_ready result handshake; data_out and err held until taken
//   core_start         one-cycle request pulse to the core
//   core_block         core input, stable from core_start until core_done
//   core_result        core output, sampled in the core_done cycle
//   core_done          one-cycle completion pulse from the core
module aes_mode_stream_ctrl #(
    parameter int unsigned DATA_W = 180
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] data_in,
    input  logic [1:0]        mode,
    input  logic              decrypt,
    input  logic [127:0]      iv,
    input  logic [127:0]      nonce,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] data_out,
    output logic              err,
    output logic              core_start,
    output logic [127:0]      core_block,
    input  logic [127:0]      core_result,
    input  logic              core_done
);

    localparam int unsigned NBLK  = (DATA_W + 127) / 128;
    localparam int unsigned PADW  = NBLK * 128;
    localparam int unsigned PAD   = PADW - DATA_W;
    localparam int unsigned IDX_W = (NBLK > 1) ? $clog2(NBLK) : 1;
    localparam int unsigned SH_W  = IDX_W + 7;

    localparam logic [1:0] MODE_CFB = 2'd0;
    localparam logic [1:0] MODE_OFB = 2'd1;
    localparam logic [1:0] MODE_CTR = 2'd2;
    localparam logic [1:0] MODE_RSV = 2'd3;

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_UPD,
        S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [127:0]       fb_q, fb_d;
    logic [127:0]       ks_q, ks_d;
    logic [DATA_W-1:0]  msg_q, msg_d;
    logic [1:0]         mode_q, mode_d;
    logic               dec_q, dec_d;
    logic [DATA_W-1:0]  res_q, res_d;
    logic               err_q, err_d;
    logic               out_valid_q, out_valid_d;
    logic               in_ready_q, in_ready_d;
    logic               core_start_q, core_start_d;
    logic [127:0]       core_block_q, core_block_d;

    // Block datapath: current block selected by shifting the padded message
    logic [PADW-1:0]    msg_wide;
    logic [PADW-1:0]    res_wide;
    logic [PADW-1:0]    res_upd;
    logic [IDX_W-1:0]   blk_from_lsb;
    logic [SH_W-1:0]    blk_shift;
    logic [127:0]       data_blk;
    logic [127:0]       out_blk;
    logic [127:0]       fb_next;
    logic [127:0]       init_fb;

    always_comb begin
        msg_wide     = PADW'(msg_q) << PAD;
        res_wide     = PADW'(res_q) << PAD;
        blk_from_lsb = IDX_W'(NBLK - 1) - idx_q;
        blk_shift    = {blk_from_lsb, 7'd0};
        data_blk     = 128'(msg_wide >> blk_shift);
        // Pad bits of the partial block are zero; their XOR output is dropped on the >> PAD
        out_blk      = data_blk ^ ks_q;
        res_upd      = (res_wide & ~(PADW'({128{1'b1}}) << blk_shift))
                     | (PADW'(out_blk) << blk_shift);
        init_fb      = (mode == MODE_CTR) ? nonce : iv;
        case (mode_q)
            MODE_CFB: fb_next = dec_q ? data_blk : out_blk;
            MODE_OFB: fb_next = ks_q;
            MODE_CTR: fb_next = fb_q + 128'd1;
            default:  fb_next = fb_q;
        endcase
    end

    // State and output registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            idx_q        <= '0;
            fb_q         <= '0;
            ks_q         <= '0;
            msg_q        <= '0;
            mode_q       <= '0;
            dec_q        <= 1'b0;
            res_q        <= '0;
            err_q        <= 1'b0;
            out_valid_q  <= 1'b0;
            in_ready_q   <= 1'b1;
            core_start_q <= 1'b0;
            core_block_q <= '0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            fb_q         <= fb_d;
            ks_q         <= ks_d;
            msg_q        <= msg_d;
            mode_q       <= mode_d;
            dec_q        <= dec_d;
            res_q        <= res_d;
            err_q        <= err_d;
            out_valid_q  <= out_valid_d;
            in_ready_q   <= in_ready_d;
            core_start_q <= core_start_d;
            core_block_q <= core_block_d;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        fb_d         = fb_q;
        ks_d         = ks_q;
        msg_d        = msg_q;
        mode_d       = mode_q;
        dec_d        = dec_q;
        res_d        = res_q;
        err_d        = err_q;
        out_valid_d  = out_valid_q;
        core_start_d = 1'b0;
        core_block_d = core_block_q;

        case (state_q)
            S_IDLE: begin
                if (in_valid && in_ready_q) begin
                    msg_d  = data_in;
                    mode_d = mode;
                    dec_d  = decrypt;
                    idx_d  = '0;
                    res_d  = '0;
                    if (mode == MODE_RSV) begin
                        err_d   = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        fb_d         = init_fb;
                        core_block_d = init_fb;
                        core_start_d = 1'b1;
                        state_d      = S_REQ;
                    end
                end
            end
            S_REQ: begin
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (core_done) begin
                    ks_d    = core_result;
                    state_d = S_UPD;
                end
            end
            S_UPD: begin
                res_d = DATA_W'(res_upd >> PAD);
                fb_d  = fb_next;
                if (idx_q == IDX_W'(NBLK - 1)) begin
                    state_d = S_DONE;
                end else begin
                    idx_d        = idx_q + IDX_W'(1);
                    core_block_d = fb_next;
                    core_start_d = 1'b1;
                    state_d      = S_REQ;
                end
            end
            S_DONE: begin
                // out_valid rises on the first edge spent in DONE
                if (out_valid_q && out_ready) begin
                    out_valid_d = 1'b0;
                    err_d       = 1'b0;
                    state_d     = S_IDLE;
                end else begin
                    out_valid_d = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        in_ready_d = (state_d == S_IDLE);
    end

    assign in_ready   = in_ready_q;
    assign out_valid  = out_valid_q;
    assign data_out   = res_q;
    assign err        = err_q;
    assign core_start = core_start_q;
    assign core_block = core_block_q;

endmodule
